// File: rtl/fetch_pkg.sv
// Shared types and geometry helpers for the instruction-fetch stage and its cache array.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_words);
    return 30 - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data storage: one registered read port, word write,
// tag/valid write and a flash clear of all valid bits.
module icache_array
  import fetch_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  localparam int IW  = idx_w(LINES),
  localparam int OFF = off_w(LINE_WORDS),
  localparam int OW  = (OFF > 0) ? OFF : 1,
  localparam int TW  = tag_w(LINES, LINE_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en_i,
  input  logic [IW-1:0] rd_idx_i,
  input  logic [OW-1:0] rd_off_i,
  output logic          rd_valid_o,
  output logic [TW-1:0] rd_tag_o,
  output logic [31:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [OW-1:0] wr_off_i,
  input  logic [31:0]   wr_data_i,
  input  logic          tv_we_i,
  input  logic [IW-1:0] tv_idx_i,
  input  logic [TW-1:0] tv_tag_i,
  input  logic          tv_valid_i,
  input  logic          clr_i
);

  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][LINE_WORDS];
  logic [LINES-1:0] valid_q;
  logic             rd_valid_q;
  logic [TW-1:0]    rd_tag_q;
  logic [31:0]      rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) data_mem[wr_idx_i][wr_off_i] <= wr_data_i;
    if (tv_we_i) tag_mem[tv_idx_i] <= tv_tag_i;
    if (rd_en_i) begin
      rd_tag_q  <= tag_mem[rd_idx_i];
      rd_data_q <= data_mem[rd_idx_i][rd_off_i];
    end
  end

  // A clear in the read cycle must already hide the line, so the read masks it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (clr_i)        valid_q <= '0;
      else if (tv_we_i) valid_q[tv_idx_i] <= tv_valid_i;
      if (rd_en_i) rd_valid_q <= valid_q[rd_idx_i] & ~clr_i;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_tag_o   = rd_tag_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/icache_fetch.sv
// Instruction-fetch stage: direct-mapped I-cache lookup, line refill over a
// per-word req/ack handshake, and fence.i flash invalidate.
module icache_fetch
  import fetch_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic [31:0] fetch_addr,
  input  logic        invalidate,
  output logic        fetch_valid,
  output logic [31:0] instr_fetch,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OFF = off_w(LINE_WORDS);
  localparam int IW  = idx_w(LINES);
  localparam int TW  = tag_w(LINES, LINE_WORDS);
  localparam int OW  = (OFF > 0) ? OFF : 1;

  fetch_state_t  state_q;
  logic [31:2]   req_addr_q;
  logic [OW-1:0] fill_cnt_q, f_off, r_off;
  logic [IW-1:0] f_idx, r_idx;
  logic [TW-1:0] r_tag, rd_tag;
  logic          cancel_q, fetch_valid_q, mem_req_q;
  logic [31:0]   instr_q, hold_q, mem_addr_q, mem_addr_d, rd_data;
  logic          rd_en, rd_valid, hit, ack, last;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^fetch_addr[1:0];

  assign f_idx = fetch_addr[OFF+IW+1:OFF+2];
  assign r_idx = req_addr_q[OFF+IW+1:OFF+2];
  assign r_tag = req_addr_q[31:OFF+IW+2];

  generate
    if (OFF > 0) begin : g_off
      assign f_off = fetch_addr[OFF+1:2];
      assign r_off = req_addr_q[OFF+1:2];
    end else begin : g_no_off
      assign f_off = '0;
      assign r_off = '0;
    end
  endgenerate

  assign mem_addr_d = {req_addr_q[31:OFF+2], {(OFF+2){1'b0}}}
                    | {{(30-OW){1'b0}}, fill_cnt_q, 2'b00};

  assign rd_en = (state_q == IDLE) && fetch_enable;
  assign hit   = rd_valid && (rd_tag == r_tag);
  assign ack   = (state_q == REFILL) && mem_req_q && mem_ack;
  assign last  = (fill_cnt_q == OW'(LINE_WORDS - 1));

  icache_array #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) u_array (
    .clk        (CLK),
    .rst        (reset),
    .rd_en_i    (rd_en),
    .rd_idx_i   (f_idx),
    .rd_off_i   (f_off),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (ack),
    .wr_idx_i   (r_idx),
    .wr_off_i   (fill_cnt_q),
    .wr_data_i  (mem_rdata),
    .tv_we_i    (ack && last),
    .tv_idx_i   (r_idx),
    .tv_tag_i   (r_tag),
    .tv_valid_i (~cancel_q),
    .clr_i      (invalidate)
  );

  // mem_req is raised one cycle after entering REFILL and after each ack,
  // so every word costs one idle cycle plus its ack wait.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      req_addr_q    <= '0;
      fill_cnt_q    <= '0;
      cancel_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
      instr_q       <= '0;
      hold_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      fetch_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (fetch_enable) begin
          req_addr_q <= fetch_addr[31:2];
          state_q    <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          instr_q       <= rd_data;
          fetch_valid_q <= 1'b1;
          state_q       <= IDLE;
        end else begin
          fill_cnt_q <= '0;
          cancel_q   <= 1'b0;
          state_q    <= REFILL;
        end
        REFILL: begin
          if (invalidate) cancel_q <= 1'b1;
          if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= mem_addr_d;
          end else if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (fill_cnt_q == r_off) hold_q <= mem_rdata;
            if (last) state_q    <= RESPOND;
            else      fill_cnt_q <= fill_cnt_q + OW'(1);
          end
        end
        RESPOND: begin
          instr_q       <= hold_q;
          fetch_valid_q <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign instr_fetch = instr_q;
  assign busy        = (state_q != IDLE);
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Bench for icache_fetch: directed vector table, hand-written corner sequences,
// and a randomized stream checked against a line-presence model.
module tb_icache_fetch;

  localparam int LINES = 16;
  localparam int LW    = 4;
  localparam int LINE_BYTES = LW * 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic [31:0] fetch_addr;
  logic        invalidate;
  logic        fetch_valid;
  logic [31:0] instr_fetch;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  icache_fetch #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .CLK(CLK), .reset(reset), .fetch_enable(fetch_enable), .fetch_addr(fetch_addr),
    .invalidate(invalidate), .fetch_valid(fetch_valid), .instr_fetch(instr_fetch),
    .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // memory-side state, written only by the memory process
  logic [31:0] req_log[$];
  int          stall_log[$];
  int          req_age = 0;
  int          cur_stall = 0;
  logic [31:0] held_addr = '0;
  int          addr_moves = 0;
  // driven by the main process only
  bit          stall_mode = 0;
  bit          late_ack_en = 0;

  // reference cache contents: line index -> tag
  logic [31:0] mtag[int];

  function automatic logic [31:0] memw(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w ^ 32'h5A5A_0000) * 32'h0001_0003 + 32'h1357_0000;
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / LINE_BYTES) % LINES);
  endfunction

  function automatic logic [31:0] m_tag(input logic [31:0] a);
    return a / (LINE_BYTES * LINES);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Instruction memory: ack arrives after `stall` extra cycles of mem_req high.
  always @(negedge CLK) begin
    mem_ack = 1'b0;
    if (mem_req && !reset) begin
      if (req_age == 0) begin
        cur_stall = stall_mode ? int'($urandom_range(0, 5)) : 0;
        req_log.push_back(mem_addr);
        stall_log.push_back(cur_stall);
        held_addr = mem_addr;
      end else if (mem_addr !== held_addr) begin
        addr_moves++;
      end
      if (req_age == cur_stall) begin
        mem_ack   = 1'b1;
        mem_rdata = memw(mem_addr);
        req_age   = 0;
      end else begin
        req_age++;
      end
    end else begin
      req_age = 0;
      if (late_ack_en) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
      end
    end
  end

  // One fetch from IDLE. exp_lat<0: derive miss latency from the stalls used.
  // inv_k>=0: pulse invalidate during cycle k after acceptance (0 = lookup cycle).
  task automatic do_fetch(input logic [31:0] a, input bit exp_hit, input int exp_lat,
                          input int inv_k, input string nm);
    int lat, q0, want;
    bit seen;
    q0 = req_log.size();
    fetch_addr   = a;
    fetch_enable = 1'b1;
    @(posedge CLK); #1;
    fetch_enable = 1'b0;
    fetch_addr   = $urandom;
    chk({nm, " accept busy/valid"}, {30'd0, busy, fetch_valid}, 32'h2);
    lat  = 0;
    seen = 0;
    if (inv_k == 0) invalidate = 1'b1;
    while (!seen && lat < 300) begin
      @(posedge CLK); #1;
      lat++;
      invalidate = 1'b0;
      if (fetch_valid) seen = 1;
      else if (lat == inv_k) invalidate = 1'b1;
    end
    invalidate = 1'b0;
    chk({nm, " fetch_valid seen"}, {31'd0, seen}, 32'd1);
    chk({nm, " instr"}, instr_fetch, memw(a));
    chk({nm, " mem reqs"}, req_log.size() - q0, exp_hit ? 0 : LW);
    if (!exp_hit && req_log.size() - q0 == LW) begin
      for (int k = 0; k < LW; k++)
        chk({nm, " mem_addr"}, req_log[q0 + k], (a & ~32'(LINE_BYTES - 1)) + 32'(4 * k));
    end
    if (exp_lat > 0) want = exp_lat;
    else if (exp_hit) want = 1;
    else begin
      want = 2;
      for (int k = q0; k < stall_log.size(); k++) want += stall_log[k] + 2;
    end
    chk({nm, " latency"}, lat, want);
    if (inv_k >= 0 && inv_k < lat) begin
      mtag.delete();
      if (!exp_hit && inv_k == 0) mtag[m_idx(a)] = m_tag(a);
    end else if (!exp_hit) begin
      mtag[m_idx(a)] = m_tag(a);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    int          lat;
    string       nm;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] a;
    int inv_k;
    bit h;

    vecs[0] = '{32'h0000_0008, 1'b0, 10, "cold miss 0x8"};
    vecs[1] = '{32'h0000_0004, 1'b1, 1,  "hit 0x4"};
    vecs[2] = '{32'h0000_000E, 1'b1, 1,  "hit 0xC lsbs"};
    vecs[3] = '{32'h0000_0100, 1'b0, 10, "conflict 0x100"};
    vecs[4] = '{32'h0000_0000, 1'b0, 10, "re-miss 0x0"};
    vecs[5] = '{32'h0000_0104, 1'b0, 10, "conflict 0x104"};
    vecs[6] = '{32'h0000_0010, 1'b0, 10, "miss line1"};
    vecs[7] = '{32'h0000_001C, 1'b1, 1,  "hit line1"};
    vecs[8] = '{32'hFFFF_FFFC, 1'b0, 10, "miss top line"};
    vecs[9] = '{32'hFFFF_FFF0, 1'b1, 1,  "hit top line"};

    reset = 1'b1; fetch_enable = 1'b0; fetch_addr = '0; invalidate = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
    chk("reset instr_fetch", instr_fetch, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    reset = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 10; i++)
      do_fetch(vecs[i].addr, vecs[i].hit, vecs[i].lat, -1, vecs[i].nm);

    // invalidate at the second ack: response still delivered, line left invalid
    do_fetch(32'h0000_0208, 1'b0, 10, 4, "inv in refill");
    do_fetch(32'h0000_0208, 1'b0, 10, -1, "refetch after inv");
    do_fetch(32'h0000_020C, 1'b1, 1, -1, "hit after refetch");
    // invalidate during a hitting lookup: hit delivered, next access misses
    do_fetch(32'h0000_0200, 1'b1, 1, 0, "inv on hit");
    do_fetch(32'h0000_0200, 1'b0, 10, -1, "miss after inv hit");
    do_fetch(32'h0000_0204, 1'b1, 1, -1, "b2b hit a");
    do_fetch(32'h0000_0208, 1'b1, 1, -1, "b2b hit b");

    // reset in the middle of a refill
    fetch_addr = 32'h0000_0300; fetch_enable = 1'b1;
    @(posedge CLK); #1;
    fetch_enable = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid-refill reset mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid-refill reset busy", {31'd0, busy}, 32'd0);
    chk("mid-refill reset fetch_valid", {31'd0, fetch_valid}, 32'd0);
    mtag.delete();
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    late_ack_en = 1'b1;
    @(posedge CLK); #1;
    late_ack_en = 1'b0;
    chk("late ack mem_req", {31'd0, mem_req}, 32'd0);
    chk("late ack busy", {31'd0, busy}, 32'd0);
    chk("late ack fetch_valid", {31'd0, fetch_valid}, 32'd0);
    do_fetch(32'h0000_0300, 1'b0, 10, -1, "after reset 0x300");
    do_fetch(32'h0000_0204, 1'b0, 10, -1, "after reset 0x204");

    // random stream with ack stalls and occasional invalidates
    stall_mode = 1;
    for (int n = 0; n < 200; n++) begin
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      h = mtag.exists(m_idx(a)) && (mtag[m_idx(a)] == m_tag(a));
      inv_k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
      do_fetch(a, h, -1, inv_k, "rand");
    end

    @(posedge CLK); #1;
    chk("final fetch_valid low", {31'd0, fetch_valid}, 32'd0);
    chk("mem_addr stable while req", addr_moves, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Instruction-fetch stage that sits directly upstream of the main controller. It accepts a fetch address whenever the controller raises `fetch_enable` and returns one 32-bit instruction with a single-cycle `fetch_valid` pulse. Instructions come from a small direct-mapped instruction cache, which refills whole lines from instruction memory over a per-word req/ack handshake. The block also supports a full-cache invalidate for `fence.i`.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; must be a power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; must be a power of two, at least 1.

Ports:
- `CLK` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `fetch_enable` in 1: fetch request from the controller.
- `fetch_addr` in 32: byte address to fetch (the controller's `nextPC`). Bits [1:0] are ignored.
- `invalidate` in 1: one-cycle pulse that clears all valid bits.
- `fetch_valid` out 1: one-cycle pulse; `instr_fetch` is valid during that cycle.
- `instr_fetch` out 32: fetched instruction. Holds its value until the next `fetch_valid`.
- `busy` out 1: high whenever the state is not IDLE.
- `mem_req` out 1: word read request; held high until acknowledged.
- `mem_addr` out 32: word-aligned address for the read request.
- `mem_ack` in 1: one-cycle acknowledge; `mem_rdata` is valid in that cycle.
- `mem_rdata` in 32: read data from instruction memory.

## Operation
Address split:
- offset = addr[OFF+1:2], where OFF = log2(LINE_WORDS)
- index = addr[OFF+IDX+1:OFF+2], where IDX = log2(LINES)
- tag = addr[31:OFF+IDX+2]

State machine:
- IDLE
  - If `fetch_enable`=1: capture `fetch_addr` into `req_addr`, start the synchronous array read, go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP
  - Hit (valid and tag match): drive `instr_fetch` = data word, pulse `fetch_valid`, go to IDLE.
  - Miss: set `fill_cnt`=0, go to REFILL.
- REFILL
  - `mem_req`=1, `mem_addr` = {tag, index, fill_cnt, 2'b00}.
  - On `mem_ack`: write `mem_rdata` into word `fill_cnt` of the line. If the word is the requested offset, latch it into the hold register.
  - When `fill_cnt` = LINE_WORDS-1 and `mem_ack`=1: write the tag, set valid (unless cancelled, see below), go to RESPOND.
  - Otherwise increment `fill_cnt`.
- RESPOND
  - Drive `instr_fetch` from the hold register, pulse `fetch_valid`, go to IDLE.

Request and response rules:
- `fetch_enable` is sampled only in IDLE. The controller keeps it high until it is served; it is ignored in every other state.
- `fetch_valid` is always exactly one cycle, exactly once per accepted request.
- `mem_ack` is ignored while `mem_req`=0.
- `mem_addr` and `mem_req` are stable from assertion until `mem_ack`.

Boundary conditions:
- `invalidate` clears all valid bits in the cycle it is sampled, in every state.
- `invalidate` during REFILL: the refill completes and the response is delivered, but the line is not marked valid (a cancel flag is latched).
- `invalidate` in the same cycle as a LOOKUP hit: the hit is still delivered. The next request misses.
- `fetch_addr` changing after acceptance has no effect on the request in flight.
- `reset` mid-refill returns to IDLE immediately and drops `mem_req`. A late `mem_ack` is ignored.

## Timing
- Reset values: state IDLE, all valid bits 0, `fetch_valid`=0, `instr_fetch`=0, `busy`=0, `mem_req`=0, `mem_addr`=0, `fill_cnt`=0, cancel flag 0.
- Hit latency: request accepted at edge N, `fetch_valid` high during cycle N+1.
- Miss latency: 1 LOOKUP cycle + (sum of per-word ack waits) + 1 RESPOND cycle.
  - With a memory that acks in the cycle after `mem_req` rises: 2 + 2·LINE_WORDS cycles, because `mem_req` drops for one cycle after each ack.
- Back-to-back hits: one request every 2 cycles (IDLE, LOOKUP).
- `fetch_valid` is registered, with no combinational path from `mem_ack` or `fetch_enable`.
- Tag/valid/data arrays use synchronous read with a 1-cycle latency. Writes take effect at the next edge.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t` {IDLE, LOOKUP, REFILL, RESPOND}
  - localparam functions for OFF, IDX, TAG widths
  - reset constant `INSTR_NOP`. Reset `instr_fetch` uses 0, not NOP.
- Sub-module `icache_array`:
  - holds tag, valid and data storage, parameterised by `LINES`/`LINE_WORDS`
  - one synchronous read port, one word-write port, a tag/valid write, and a flash-clear input
  - FSM, counters and hold register stay in `icache_fetch`

## Test plan
- Cold miss: after reset, `fetch_addr`=0x0000_0008 with mem ack latency 1 → four `mem_addr` values 0x0,0x4,0x8,0xC; `fetch_valid` pulses once with the word at 0x8; total latency 10 cycles.
- Hit: then `fetch_addr`=0x0000_0004 → `fetch_valid` in the next cycle with the 0x4 word; `mem_req` stays 0.
- Conflict: `fetch_addr`=0x0000_0100 (same index as 0x0 with defaults) → refill from 0x100; a following fetch of 0x0 misses again.
- Invalidate during refill: pulse `invalidate` at the 2nd ack → response is still delivered; refetching the same address issues a new refill.
- Random ack stalls of 0–5 cycles on a mixed hit/miss stream of 200 fetches → every `fetch_valid` matches the reference memory; `mem_addr` is stable while `mem_req` is high.
- Assert `reset` during REFILL → `mem_req`=0, `fetch_valid`=0, `busy`=0 immediately; the next fetch after release misses and completes correctly.
